// File: rtl/thermo_conv_arbiter.sv
// ---------------------------------------------------------------------------
// thermo_conv_arbiter
//
// Shares one thermometer-to-binary converter among NUM_REQ requesters.
// A round-robin arbiter picks one valid requester per load opportunity. The
// popcount of its code is registered into a single output slot that is
// drained with a valid/ready handshake. Results can pass through every cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  [NUM_REQ]            per-requester code valid
//   req_thermo [NUM_REQ*THERMO_W]   codes, requester i at [i*THERMO_W +: THERMO_W]
//   req_ready  [NUM_REQ]            one-hot grant (combinational)
//   out_valid                       result valid
//   out_bin    [BIN_W]              popcount of the accepted code
//   out_id     [ID_W]               index of the requester that produced out_bin
//   out_err                         (THERMO_BUBBLE_CHK_EN only) code was not 2^k-1
//   out_ready                       downstream accept
//
// Optional feature macro: THERMO_BUBBLE_CHK_EN
//   Adds the out_err port and the bubble check registered with out_bin.
// ---------------------------------------------------------------------------
module thermo_conv_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int THERMO_W = 15,
    parameter int BIN_W    = 4,
    parameter int ID_W     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*THERMO_W-1:0]  req_thermo,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         out_valid,
    output logic [BIN_W-1:0]             out_bin,
    output logic [ID_W-1:0]              out_id,
`ifdef THERMO_BUBBLE_CHK_EN
    output logic                         out_err,
`endif
    input  logic                         out_ready
);

    typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [BIN_W-1:0]  out_bin_reg;
    logic [ID_W-1:0]   out_id_reg;

    logic                 load;
    logic                 grant_found;
    logic [ID_W-1:0]      grant_id;
    logic [THERMO_W-1:0]  sel_code;
    logic [BIN_W-1:0]     sel_count;
    logic [THERMO_W-1:0]  code_arr [NUM_REQ];

    // Unpack the flat code bus into one entry per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign code_arr[gi] = req_thermo[gi*THERMO_W +: THERMO_W];
        end
    endgenerate

    // Round-robin search: rotate the valid vector so that rr_ptr lands on
    // bit 0, take the first set bit, then map it back to a real index.
    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]   valid_rot;
    logic [ID_W:0]        idx_sum;

    always_comb begin
        valid_dbl   = {req_valid, req_valid} >> rr_ptr_reg;
        valid_rot   = valid_dbl[NUM_REQ-1:0];
        grant_found = 1'b0;
        grant_id    = '0;
        idx_sum     = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (valid_rot[j]) begin
                idx_sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(j);
                if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
                    idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
                end
                grant_found = 1'b1;
                grant_id    = idx_sum[ID_W-1:0];
            end
        end
    end

    // Convert the granted code: popcount, which equals k for legal 2^k-1.
    always_comb begin
        sel_code  = code_arr[grant_id];
        sel_count = '0;
        for (int b = 0; b < THERMO_W; b++) begin
            sel_count = sel_count + {{(BIN_W-1){1'b0}}, sel_code[b]};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            out_bin_reg <= '0;
            out_id_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            if (load && grant_found) begin
                out_bin_reg <= sel_count;
                out_id_reg  <= grant_id;
            end
        end
    end

    // Next-state logic. With load=0 (FULL and stalled) everything holds.
    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        if (load) begin
            if (grant_found) begin
                state_next  = FULL;
                rr_ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end else begin
                state_next  = IDLE;
            end
        end
    end

    // Output logic. out_valid mirrors FULL, so load is IDLE or a drain.
    always_comb begin
        out_valid = (state_reg == FULL);
        load      = (state_reg == IDLE) || (out_ready && out_valid);
    end

    // Grant is gated by rst so nothing is consumed while held in reset.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = !rst && load && grant_found && (grant_id == ID_W'(gi));
        end
    endgenerate

    assign out_bin = out_bin_reg;
    assign out_id  = out_id_reg;

`ifdef THERMO_BUBBLE_CHK_EN
    logic out_err_reg;
    logic sel_bubble;

    // A legal thermometer code has no zero below its highest one.
    assign sel_bubble = (sel_code & (sel_code + THERMO_W'(1))) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_err_reg <= 1'b0;
        end else if (load && grant_found) begin
            out_err_reg <= sel_bubble;
        end
    end

    assign out_err = out_err_reg;
`endif

endmodule
